// File: rtl/flag_register_stage.sv
// flag_register_stage: one-entry pipeline register after the ALU that holds
// the ARM-style {N,Z,C} flag register, evaluates the instruction's condition
// code against the current flags and gates the register write accordingly.
// Optional feature macro: FLAG_OVERFLOW_EN adds an overflow input, widens the
// flags to {N,Z,C,V} and enables the V-dependent condition codes.
module flag_register_stage #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned REG_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                valid_in,
  output logic                ready_in,
  input  logic [WIDTH-1:0]    salida,
  input  logic                cout,
  input  logic                zero,
  input  logic                negative,
`ifdef FLAG_OVERFLOW_EN
  input  logic                overflow,
`endif
  input  logic                set_flags,
  input  logic [3:0]          cond,
  input  logic [REG_BITS-1:0] rd,
  input  logic                reg_write,
  input  logic                flush,
  output logic                valid_out,
  input  logic                ready_out,
  output logic [WIDTH-1:0]    result_out,
  output logic [REG_BITS-1:0] rd_out,
  output logic                reg_write_out,
`ifdef FLAG_OVERFLOW_EN
  output logic [3:0]          flags_q,
`else
  output logic [2:0]          flags_q,
`endif
  output logic                cond_pass
);

`ifdef FLAG_OVERFLOW_EN
  localparam int unsigned FW = 4;
`else
  localparam int unsigned FW = 3;
`endif

  logic          flag_n;
  logic          flag_z;
  logic          flag_c;
  logic          pass;
  logic          accept;
  logic [FW-1:0] flags_new;

  assign flag_n = flags_q[FW-1];
  assign flag_z = flags_q[FW-2];
  assign flag_c = flags_q[FW-3];

`ifdef FLAG_OVERFLOW_EN
  logic flag_v;
  assign flag_v    = flags_q[0];
  assign flags_new = {negative, zero, cout, overflow};
`else
  assign flags_new = {negative, zero, cout};
`endif

  // Stage accepts when empty or draining, never while flushing
  assign ready_in = (!valid_out || ready_out) && !flush;
  assign accept   = valid_in && ready_in;

  // Condition outcome against the flags as they stand before this instruction
  always_comb begin
    pass = 1'b0;
    case (cond)
      4'b0000: pass = flag_z;
      4'b0001: pass = !flag_z;
      4'b0010: pass = flag_c;
      4'b0011: pass = !flag_c;
      4'b0100: pass = flag_n;
      4'b0101: pass = !flag_n;
      4'b1000: pass = flag_c && !flag_z;
      4'b1001: pass = !flag_c || flag_z;
      4'b1110: pass = 1'b1;
`ifdef FLAG_OVERFLOW_EN
      4'b0110: pass = flag_v;
      4'b0111: pass = !flag_v;
      4'b1010: pass = (flag_n == flag_v);
      4'b1011: pass = (flag_n != flag_v);
      4'b1100: pass = !flag_z && (flag_n == flag_v);
      4'b1101: pass = flag_z || (flag_n != flag_v);
      4'b1111: pass = 1'b0;
`endif
      default: pass = 1'b0;
    endcase
  end

  // Output entry register and flag register; flush overrides accept and drain
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out     <= 1'b0;
      reg_write_out <= 1'b0;
      cond_pass     <= 1'b0;
      result_out    <= '0;
      rd_out        <= '0;
      flags_q       <= '0;
    end else if (flush) begin
      valid_out     <= 1'b0;
      reg_write_out <= 1'b0;
    end else if (accept) begin
      valid_out     <= 1'b1;
      result_out    <= salida;
      rd_out        <= rd;
      cond_pass     <= pass;
      reg_write_out <= reg_write && pass;
      if (pass && set_flags) begin
        flags_q <= flags_new;
      end
    end else if (valid_out && ready_out) begin
      valid_out     <= 1'b0;
      reg_write_out <= 1'b0;
    end
  end

endmodule

// File: tb/tb_flag_register_stage.sv
// Directed bench for flag_register_stage; expected values hand-computed.
// Builds with or without FLAG_OVERFLOW_EN; the V-dependent expectations follow.
module tb_flag_register_stage;

  localparam int unsigned WIDTH    = 32;
  localparam int unsigned REG_BITS = 4;
`ifdef FLAG_OVERFLOW_EN
  localparam int unsigned FW = 4;
`else
  localparam int unsigned FW = 3;
`endif

  logic                clk;
  logic                rst_n;
  logic                valid_in;
  logic                ready_in;
  logic [WIDTH-1:0]    salida;
  logic                cout;
  logic                zero;
  logic                negative;
`ifdef FLAG_OVERFLOW_EN
  logic                overflow;
`endif
  logic                set_flags;
  logic [3:0]          cond;
  logic [REG_BITS-1:0] rd;
  logic                reg_write;
  logic                flush;
  logic                valid_out;
  logic                ready_out;
  logic [WIDTH-1:0]    result_out;
  logic [REG_BITS-1:0] rd_out;
  logic                reg_write_out;
  logic [FW-1:0]       flags_q;
  logic                cond_pass;

  int n_tests = 0;
  int n_fail  = 0;

  flag_register_stage #(.WIDTH(WIDTH), .REG_BITS(REG_BITS)) dut (
    .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .ready_in(ready_in),
    .salida(salida), .cout(cout), .zero(zero), .negative(negative),
`ifdef FLAG_OVERFLOW_EN
    .overflow(overflow),
`endif
    .set_flags(set_flags), .cond(cond), .rd(rd), .reg_write(reg_write),
    .flush(flush), .valid_out(valid_out), .ready_out(ready_out),
    .result_out(result_out), .rd_out(rd_out), .reg_write_out(reg_write_out),
    .flags_q(flags_q), .cond_pass(cond_pass)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Expected flag vector in the build's layout
  function automatic logic [FW-1:0] mkf(input logic n, input logic z,
                                        input logic c, input logic v);
`ifdef FLAG_OVERFLOW_EN
    return {n, z, c, v};
`else
    return {n, z, c} | {3{v & 1'b0}};
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic present(input logic [3:0] c, input logic sf, input logic [31:0] s,
                         input logic [3:0] r);
    valid_in  = 1'b1;
    cond      = c;
    set_flags = sf;
    salida    = s;
    rd        = r;
    reg_write = 1'b1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

  logic [3:0]  cond_tab [6] = '{4'b0011, 4'b1000, 4'b1001, 4'b0101, 4'b0100, 4'b0001};
  logic        pass_tab [6] = '{1'b0,    1'b1,    1'b0,    1'b1,    1'b0,    1'b1};
  logic [31:0] held;
  logic [FW-1:0] f_before;

  initial begin
    rst_n = 1'b0; valid_in = 1'b0; salida = '0; cout = 1'b0; zero = 1'b0;
    negative = 1'b0; set_flags = 1'b0; cond = 4'b0000; rd = '0;
    reg_write = 1'b0; flush = 1'b0; ready_out = 1'b1;
`ifdef FLAG_OVERFLOW_EN
    overflow = 1'b0;
`endif
    #2;
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_flags", 32'(flags_q), 32'd0);
    check("rst_result", result_out, 32'd0);
    check("rst_rd", 32'(rd_out), 32'd0);
    check("rst_rw", 32'(reg_write_out), 32'd0);
    check("rst_pass", 32'(cond_pass), 32'd0);
    check("rst_ready_in", 32'(ready_in), 32'd1);
    #10 rst_n = 1'b1;
    step();

    // Failed EQ with flags 000: passes through, no write, no flag update
    present(4'b0000, 1'b1, 32'h5, 4'd3);
    negative = 1'b1;
    step();
    check("fail_valid", 32'(valid_out), 32'd1);
    check("fail_rw", 32'(reg_write_out), 32'd0);
    check("fail_pass", 32'(cond_pass), 32'd0);
    check("fail_flags", 32'(flags_q), 32'(mkf(0, 0, 0, 0)));
    check("fail_result", result_out, 32'h5);
    check("fail_rd", 32'(rd_out), 32'd3);

    // AL sets Z, then EQ back-to-back sees Z
    present(4'b1110, 1'b1, 32'h0, 4'd1);
    negative = 1'b0; zero = 1'b1;
    step();
    check("al_pass", 32'(cond_pass), 32'd1);
    check("al_rw", 32'(reg_write_out), 32'd1);
    check("al_flags", 32'(flags_q), 32'(mkf(0, 1, 0, 0)));
    present(4'b0000, 1'b0, 32'hAA, 4'd2);
    step();
    check("eq_valid", 32'(valid_out), 32'd1);
    check("eq_pass", 32'(cond_pass), 32'd1);
    check("eq_rw", 32'(reg_write_out), 32'd1);
    check("eq_flags", 32'(flags_q), 32'(mkf(0, 1, 0, 0)));
    check("eq_result", result_out, 32'hAA);
    check("eq_rd", 32'(rd_out), 32'd2);

    // Set C only, then sweep conditions with flags held
    present(4'b1110, 1'b1, 32'h1, 4'd4);
    zero = 1'b0; cout = 1'b1;
    step();
    check("c_flags", 32'(flags_q), 32'(mkf(0, 0, 1, 0)));
    for (int i = 0; i < 6; i++) begin
      present(cond_tab[i], 1'b0, 32'(i + 16), 4'(i));
      step();
      check($sformatf("cond_%b_pass", cond_tab[i]), 32'(cond_pass), 32'(pass_tab[i]));
      check($sformatf("cond_%b_rw", cond_tab[i]), 32'(reg_write_out), 32'(pass_tab[i]));
    end
    check("sweep_flags", 32'(flags_q), 32'(mkf(0, 0, 1, 0)));

    // Overflow flag and V-dependent conditions
    present(4'b1110, 1'b1, 32'h2, 4'd5);
    cout = 1'b0; zero = 1'b0; negative = 1'b0;
`ifdef FLAG_OVERFLOW_EN
    overflow = 1'b1;
`endif
    step();
    check("v_flags", 32'(flags_q), 32'(mkf(0, 0, 0, 1)));
`ifdef FLAG_OVERFLOW_EN
    overflow = 1'b0;
`endif
    present(4'b1011, 1'b0, 32'h3, 4'd6);
    step();
`ifdef FLAG_OVERFLOW_EN
    check("lt_pass", 32'(cond_pass), 32'd1);
`else
    check("lt_pass", 32'(cond_pass), 32'd0);
`endif
    present(4'b0110, 1'b0, 32'h4, 4'd7);
    step();
`ifdef FLAG_OVERFLOW_EN
    check("vs_pass", 32'(cond_pass), 32'd1);
`else
    check("vs_pass", 32'(cond_pass), 32'd0);
`endif
    present(4'b1111, 1'b0, 32'h6, 4'd8);
    step();
    check("nv_pass", 32'(cond_pass), 32'd0);

    // Stall: held entry stays put while downstream refuses it
    held = result_out;
    ready_out = 1'b0;
    present(4'b1110, 1'b0, 32'h77, 4'd9);
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall_ready_in", 32'(ready_in), 32'd0);
      step();
      check("stall_valid", 32'(valid_out), 32'd1);
      check("stall_result", result_out, held);
    end
    ready_out = 1'b1;
    #1;
    check("unstall_ready_in", 32'(ready_in), 32'd1);
    step();
    check("unstall_result", result_out, 32'h77);
    check("unstall_rd", 32'(rd_out), 32'd9);

    // Drain with nothing new
    valid_in = 1'b0;
    step();
    check("drain_valid", 32'(valid_out), 32'd0);

    // Flush squashes held entry and blocks the presented flag-setter
    present(4'b1110, 1'b0, 32'h8, 4'd1);
    step();
    check("pre_flush_valid", 32'(valid_out), 32'd1);
    f_before = flags_q;
    present(4'b1110, 1'b1, 32'h9, 4'd2);
    cout = 1'b1; zero = 1'b1; negative = 1'b1;
    flush = 1'b1;
    #1;
    check("flush_ready_in", 32'(ready_in), 32'd0);
    step();
    check("flush_valid", 32'(valid_out), 32'd0);
    check("flush_rw", 32'(reg_write_out), 32'd0);
    check("flush_flags", 32'(flags_q), 32'(mkf(0, 0, 0, 1)));
    check("flush_flags_hold", 32'(flags_q), 32'(f_before));
    flush = 1'b0;

    // Mid-stream asynchronous reset, then immediate accept
    present(4'b1110, 1'b1, 32'hC, 4'd3);
    cout = 1'b0; zero = 1'b0; negative = 1'b1;
    step();
    check("prerst_flags", 32'(flags_q), 32'(mkf(1, 0, 0, 0)));
    ready_out = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", 32'(valid_out), 32'd0);
    check("arst_flags", 32'(flags_q), 32'd0);
    check("arst_result", result_out, 32'd0);
    #1 rst_n = 1'b1;
    ready_out = 1'b1;
    present(4'b1110, 1'b0, 32'h9, 4'd5);
    step();
    check("post_rst_valid", 32'(valid_out), 32'd1);
    check("post_rst_result", result_out, 32'h9);
    valid_in = 1'b0;
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/flag_register_stage.md
FLAG_REGISTER_STAGE -- requirements
Module: flag_register_stage

Interface
REQ-001 Parameter: WIDTH, 32, datapath width of the ALU result.
REQ-002 Parameter: REG_BITS, 4, width of the destination register index.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 valid_in  input  1  upstream ALU presents a valid result this cycle.
REQ-006 ready_in  output  1  stage can accept the presented result.
REQ-007 salida  input  WIDTH  ALU result.
REQ-008 cout, zero, negative  input  1 each  ALU carry, zero and negative flags.
REQ-009 set_flags  input  1  instruction updates the flag register (S bit).
REQ-010 cond  input  4  ARM condition code of the instruction.
REQ-011 rd  input  REG_BITS  destination register index.
REQ-012 reg_write  input  1  instruction writes rd.
REQ-013 flush  input  1  squash the held entry and the presented input.
REQ-014 valid_out  output  1  held entry is valid.
REQ-015 ready_out  input  1  downstream consumes the held entry.
REQ-016 result_out  output  WIDTH  registered result.
REQ-017 rd_out  output  REG_BITS  registered destination index.
REQ-018 reg_write_out  output  1  registered write enable, already gated by condition.
REQ-019 flags_q  output  3  architectural flags {N,Z,C}.
REQ-020 cond_pass  output  1  registered condition outcome of the held entry.

Function
REQ-021 ready_in SHALL equal (!valid_out || ready_out) && !flush, combinationally.
REQ-022 An accept SHALL occur on a rising edge when valid_in && ready_in.
REQ-023 On accept, result_out, rd_out and cond_pass SHALL load, valid_out SHALL become 1, and reg_write_out SHALL load reg_write && pass.
REQ-024 pass SHALL be evaluated combinationally from the incoming cond against the current flags_q, before any update from that same instruction.
REQ-025 Condition table: 0000 Z; 0001 !Z; 0010 C; 0011 !C; 0100 N; 0101 !N; 1000 C&&!Z; 1001 !C||Z; 1110 1; all other codes 0, subject to REQ-036.
REQ-026 On accept with pass && set_flags, flags_q SHALL load {negative, zero, cout}; otherwise flags_q SHALL hold.
REQ-027 A failed-condition instruction SHALL still pass through with valid_out=1, reg_write_out=0 and cond_pass=0, so the pipeline keeps in order.
REQ-028 Back-to-back accepts: the second instruction SHALL see flags written by the first, with no bubble.
REQ-029 Without an accept, when ready_out && valid_out, valid_out SHALL clear next edge.
REQ-030 While valid_out && !ready_out, all outputs SHALL hold stable.
REQ-031 flush SHALL clear valid_out and reg_write_out next edge, block any accept that cycle, and leave flags_q unchanged; flush takes priority over every other event.
REQ-032 Latency: input to output is exactly one cycle; full throughput when ready_out stays high.

Reset
REQ-033 While rst_n=0: valid_out=0, reg_write_out=0, cond_pass=0, result_out=0, rd_out=0, flags_q=3'b000, all asynchronously.
REQ-034 Reset asserted mid-transfer SHALL discard the held entry, with no partial flag update.
REQ-035 After rst_n deasserts, the first accept SHALL be possible on the first rising edge.

Configuration
REQ-036 Macro FLAG_OVERFLOW_EN: when defined, an input overflow (1 bit) is added, flags_q widens to 4 bits {N,Z,C,V}, REQ-026 also loads V, and conditions decode fully as follows: 0110 V; 0111 !V; 1010 N==V; 1011 N!=V; 1100 !Z&&(N==V); 1101 Z||(N!=V); 1111 0. When undefined, there is no V, flags_q is 3 bits, and those codes evaluate 0.

Verification
REQ-037 Reset: rst_n=0 mid-stream -> valid_out=0, flags_q=000 immediately, before any clock edge.
REQ-038 Flag set then EQ: accept salida=0, zero=1, set_flags=1, cond=1110; next cycle accept cond=0000, reg_write=1 -> second entry has cond_pass=1, reg_write_out=1, flags_q=010.
REQ-039 Failed condition: flags_q=000, accept cond=0000, set_flags=1, negative=1 -> reg_write_out=0, cond_pass=0, flags_q stays 000.
REQ-040 Stall: valid_out=1, ready_out=0 for 3 cycles with valid_in=1 -> ready_in=0, result_out stable; ready_out=1 -> next entry accepted in the same cycle.
REQ-041 Flush: flush=1 with valid_in=1, set_flags=1 -> valid_out=0 next cycle, flags_q unchanged, ready_in=0 during flush.
REQ-042 FLAG_OVERFLOW_EN: overflow=1, negative=0, set_flags=1, then cond=1011 -> cond_pass=1; without the macro, cond=1011 -> cond_pass=0.
